// File: rtl/citadel_pkg.sv
// Shared definitions for the Gerlinsky Guard responder: FSM state encoding,
// default thresholds and a small width helper.
`timescale 1ns/1ps
package citadel_pkg;

  // Responder FSM states; encodings are visible on the debug state port.
  typedef enum logic [1:0] {
    GG_DISARMED = 2'd0,
    GG_MONITOR  = 2'd1,
    GG_WIPE     = 2'd2,
    GG_LOCKOUT  = 2'd3
  } gg_state_e;

  localparam int unsigned GG_SYNC_STAGES_DEF = 2;
  localparam int unsigned GG_CNT_W_DEF       = 4;
  localparam int unsigned GG_THRESH_DEF      = 4;
  localparam int unsigned GG_WIPE_CYCLES_DEF = 16;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned gg_width_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/glitch_guard_responder_if.sv
// Sensor/control/status bundle of the glitch guard responder.
// master = sensor mesh and control side, slave = responder.
`timescale 1ns/1ps
interface glitch_guard_responder_if #(
  parameter int unsigned CNT_W = 4
);
  logic             glitch_raw;
  logic             arm;
  logic             ack;
  logic             wipe;
  logic             alarm;
  logic             lockout;
  logic [CNT_W-1:0] glitch_cnt;
  logic [1:0]       state;

  modport master (
    output glitch_raw, arm, ack,
    input  wipe, alarm, lockout, glitch_cnt, state
  );

  modport slave (
    input  glitch_raw, arm, ack,
    output wipe, alarm, lockout, glitch_cnt, state
  );
endinterface

// File: rtl/glitch_guard_responder_sync.sv
// glitch_sync: brings the asynchronous sensor output into the clk domain and
// turns each rising edge into a single-cycle event.
// Optional feature macro: CITADEL_GLITCH_STRETCH_EN adds an asynchronous
// catcher so pulses that fall between clock edges are still seen.
`timescale 1ns/1ps
module glitch_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic glitch_raw,
  output logic glitch_evt_c
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   last_q;
  logic                   sync_in;

`ifdef CITADEL_GLITCH_STRETCH_EN
  logic catch_q;
  logic catch_clr;

  // Release the catcher once the pulse has reached the end of the chain.
  assign catch_clr = chain_q[SYNC_STAGES-1];

  // Catcher: set by any sensor rising edge, however short the pulse.
  always_ff @(posedge glitch_raw or posedge catch_clr or negedge rst_n) begin
    if (!rst_n) begin
      catch_q <= 1'b0;
    end else if (catch_clr) begin
      catch_q <= 1'b0;
    end else begin
      catch_q <= 1'b1;
    end
  end

  // Raw level still passes through so a held-high sensor is never lost.
  assign sync_in = glitch_raw | catch_q;
`else
  assign sync_in = glitch_raw;
`endif

  // Synchroniser chain plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      last_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], sync_in};
      last_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  // One-cycle event on each rising edge at the chain output.
  assign glitch_evt_c = chain_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/glitch_guard_responder.sv
// glitch_guard_responder: counts synchronised glitch events, drives a timed
// tactical-wipe strobe and escalates to a permanent lockout after THRESH events.
// Optional feature macro (in glitch_sync): CITADEL_GLITCH_STRETCH_EN.
`timescale 1ns/1ps
module glitch_guard_responder
  import citadel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = GG_SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = GG_CNT_W_DEF,
  parameter int unsigned THRESH      = GG_THRESH_DEF,
  parameter int unsigned WIPE_CYCLES = GG_WIPE_CYCLES_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  glitch_guard_responder_if.slave bus
);

  localparam int unsigned TMR_W = gg_width_min1(WIPE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WIPE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESH);

  gg_state_e        state_q;
  logic             wipe_q;
  logic             alarm_q;
  logic             lockout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] timer_q;
  logic             evt_c;
  logic [CNT_W-1:0] cnt_inc_c;

  glitch_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .glitch_raw   (bus.glitch_raw),
    .glitch_evt_c (evt_c)
  );

  // Saturating increment: the count holds at all-ones instead of wrapping.
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Responder FSM with registered wipe/alarm/lockout/count outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GG_DISARMED;
      wipe_q    <= 1'b0;
      alarm_q   <= 1'b0;
      lockout_q <= 1'b0;
      cnt_q     <= '0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        GG_DISARMED: begin
          if (bus.arm) begin
            state_q <= GG_MONITOR;
          end
        end
        GG_MONITOR: begin
          if (evt_c) begin
            state_q <= GG_WIPE;
            wipe_q  <= 1'b1;
            alarm_q <= 1'b1;
            cnt_q   <= cnt_inc_c;
            timer_q <= TMR_LOAD;
          end else if (!bus.arm) begin
            state_q <= GG_DISARMED;
          end else if (bus.ack) begin
            alarm_q <= 1'b0;
          end
        end
        GG_WIPE: begin
          if (evt_c) begin
            // A fresh event restarts the full wipe length.
            alarm_q <= 1'b1;
            cnt_q   <= cnt_inc_c;
            timer_q <= TMR_LOAD;
          end else if (timer_q == '0) begin
            if (cnt_q >= CNT_THR) begin
              state_q   <= GG_LOCKOUT;
              lockout_q <= 1'b1;
            end else begin
              state_q <= GG_MONITOR;
              wipe_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        GG_LOCKOUT: begin
          wipe_q    <= 1'b1;
          lockout_q <= 1'b1;
        end
        default: begin
          state_q <= GG_DISARMED;
        end
      endcase
    end
  end

  assign bus.wipe       = wipe_q;
  assign bus.alarm      = alarm_q;
  assign bus.lockout    = lockout_q;
  assign bus.glitch_cnt = cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_glitch_guard_responder.sv
// Self-checking bench for glitch_guard_responder against a cycle-level
// behavioural model of the guard's rules.
`timescale 1ns/1ps
module tb_glitch_guard_responder;

  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int TH   = 4;
  localparam int WC   = 16;
  localparam int CMAX = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  glitch_guard_responder_if #(.CNT_W(CW)) bus ();

  glitch_guard_responder #(
    .SYNC_STAGES (S),
    .CNT_W       (CW),
    .THRESH      (TH),
    .WIPE_CYCLES (WC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 disarmed, 1 monitoring, 2 wiping, 3 locked out.
  int m_mode;
  int m_left;
  int m_cnt;
  bit m_alarm;
  bit smp [0:S];
  bit short_flag;

  task automatic model_reset();
    m_mode     = 0;
    m_left     = 0;
    m_cnt      = 0;
    m_alarm    = 1'b0;
    short_flag = 1'b0;
    for (int i = 0; i <= S; i++) smp[i] = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs seen at that edge.
  task automatic model_edge();
    bit ev;
    ev = smp[S-1] && !smp[S];
    for (int i = S; i > 0; i--) smp[i] = smp[i-1];
    smp[0]     = bus.glitch_raw | short_flag;
    short_flag = 1'b0;
    case (m_mode)
      0: if (bus.arm) m_mode = 1;
      1: begin
        if (ev) begin
          m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          m_alarm = 1'b1;
          m_mode  = 2;
          m_left  = WC;
        end else if (!bus.arm) m_mode = 0;
        else if (bus.ack) m_alarm = 1'b0;
      end
      2: begin
        if (ev) begin
          m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          m_alarm = 1'b1;
          m_left  = WC;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = (m_cnt >= TH) ? 3 : 1;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [CW+4:0] exp_vec();
    return {2'(m_mode), (m_mode >= 2), m_alarm, (m_mode == 3), CW'(m_cnt)};
  endfunction

  function automatic logic [CW+4:0] obs_vec();
    return {bus.state, bus.wipe, bus.alarm, bus.lockout, bus.glitch_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.glitch_raw = 1'b0;
    bus.arm        = 1'b0;
    bus.ack        = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.glitch_raw = 1'b0;
    bus.arm        = 1'b1;
    bus.ack        = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    #12;
    vectors++; if (bus.wipe !== 1'b0) begin miscompares++; $display("FAIL reset_wipe got=%b exp=0", bus.wipe); end
    vectors++; if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL reset_alarm got=%b exp=0", bus.alarm); end
    vectors++; if (bus.lockout !== 1'b0) begin miscompares++; $display("FAIL reset_lockout got=%b exp=0", bus.lockout); end
    vectors++; if (bus.glitch_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", bus.glitch_cnt); end
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    int wl;
    int first;
    do_reset();
    bus.arm = 1'b1;
    wl = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      bus.glitch_raw = (c == 3);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL single_pulse c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      if (bus.wipe === 1'b1) begin wl++; if (first < 0) first = c; end
    end
    vectors++; if (wl !== WC) begin miscompares++; $display("FAIL single_wipe_len got=%0d exp=%0d", wl, WC); end
    vectors++; if (first !== 3 + S) begin miscompares++; $display("FAIL single_wipe_start got=%0d exp=%0d", first, 3 + S); end
    vectors++; if (bus.glitch_cnt !== 4'd1 || bus.alarm !== 1'b1 || bus.state !== 2'd1) begin
      miscompares++; $display("FAIL single_end got cnt=%0d alarm=%b st=%0d exp cnt=1 alarm=1 st=1", bus.glitch_cnt, bus.alarm, bus.state);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    bus.arm = 1'b1;
    for (int c = 0; c < 130; c++) begin
      bus.glitch_raw = (c == 2 || c == 30 || c == 58 || c == 86);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL lockout_seq c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    for (int c = 0; c < 16; c++) begin
      bus.arm        = 1'($urandom_range(0, 1));
      bus.ack        = 1'($urandom_range(0, 1));
      bus.glitch_raw = (c % 5 == 0);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL lockout_hold c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.lockout !== 1'b1 || bus.wipe !== 1'b1 || bus.state !== 2'd3 || bus.glitch_cnt !== 4'd4) begin
      miscompares++; $display("FAIL lockout_end got lk=%b w=%b st=%0d cnt=%0d exp lk=1 w=1 st=3 cnt=4", bus.lockout, bus.wipe, bus.state, bus.glitch_cnt);
    end
  endtask

  task automatic test_extend();
    int wl;
    int rises;
    logic pw;
    do_reset();
    bus.arm = 1'b1;
    wl = 0; rises = 0; pw = 1'b0;
    for (int c = 0; c < 45; c++) begin
      bus.glitch_raw = (c == 3 || c == 8);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL extend c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      if (bus.wipe === 1'b1) wl++;
      if (bus.wipe === 1'b1 && pw === 1'b0) rises++;
      pw = bus.wipe;
    end
    vectors++; if (wl !== 21) begin miscompares++; $display("FAIL extend_len got=%0d exp=21", wl); end
    vectors++; if (rises !== 1) begin miscompares++; $display("FAIL extend_contig got=%0d exp=1", rises); end
    vectors++; if (bus.glitch_cnt !== 4'd2) begin miscompares++; $display("FAIL extend_cnt got=%0d exp=2", bus.glitch_cnt); end
  endtask

  task automatic test_disarmed_ack();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      bus.glitch_raw = (c == 3 || c == 10 || c == 17);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL disarmed c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.glitch_cnt !== 4'd0 || bus.alarm !== 1'b0 || bus.wipe !== 1'b0) begin
      miscompares++; $display("FAIL disarmed_end got cnt=%0d alarm=%b w=%b exp 0 0 0", bus.glitch_cnt, bus.alarm, bus.wipe);
    end
    bus.arm = 1'b1;
    for (int c = 0; c < 34; c++) begin
      bus.glitch_raw = (c == 3);
      bus.ack        = (c == 30);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL ack c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.alarm !== 1'b0 || bus.glitch_cnt !== 4'd1 || bus.state !== 2'd1) begin
      miscompares++; $display("FAIL ack_end got alarm=%b cnt=%0d st=%0d exp 0 1 1", bus.alarm, bus.glitch_cnt, bus.state);
    end
    // Event coincides with ack high and arm low: event wins on both.
    for (int c = 0; c < 12; c++) begin
      bus.glitch_raw = (c == 3);
      bus.ack        = (c >= 3);
      bus.arm        = (c < 3 + S);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL ack_evt c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.alarm !== 1'b1 || bus.state !== 2'd2) begin
      miscompares++; $display("FAIL ack_evt_end got alarm=%b st=%0d exp 1 2", bus.alarm, bus.state);
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_reset_mid_wipe();
    int wl;
    do_reset();
    bus.arm = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.glitch_raw = (c == 3);
      tick();
    end
    vectors++; if (bus.wipe !== 1'b1) begin miscompares++; $display("FAIL midwipe_pre got=%b exp=1", bus.wipe); end
    #3;
    bus.glitch_raw = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #0.5;
    vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL midwipe_async got=%h exp=%h", obs_vec(), exp_vec()); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wl = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL held_high c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
      if (bus.wipe === 1'b1) wl++;
    end
    vectors++; if (bus.glitch_cnt !== 4'd1 || wl !== WC) begin
      miscompares++; $display("FAIL held_high_end got cnt=%0d wipe_len=%0d exp 1 %0d", bus.glitch_cnt, wl, WC);
    end
    bus.glitch_raw = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    bus.arm = 1'b1;
    for (int c = 0; c < 140; c++) begin
      bus.glitch_raw = (c >= 2 && c <= 102 && (c - 2) % 5 == 0);
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL saturate c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.glitch_cnt !== 4'd15 || bus.state !== 2'd3) begin
      miscompares++; $display("FAIL saturate_end got cnt=%0d st=%0d exp 15 3", bus.glitch_cnt, bus.state);
    end
  endtask

  task automatic test_short_pulse();
    int exp_cnt;
    do_reset();
    bus.arm = 1'b1;
    repeat (3) tick();
    #2;
    bus.glitch_raw = 1'b1;
    #0.2;
    bus.glitch_raw = 1'b0;
`ifdef CITADEL_GLITCH_STRETCH_EN
    short_flag = 1'b1;
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    for (int c = 0; c < 25; c++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL short c=%0d got=%h exp=%h", c, obs_vec(), exp_vec()); end
    end
    vectors++; if (bus.glitch_cnt !== CW'(exp_cnt)) begin
      miscompares++; $display("FAIL short_cnt got=%0d exp=%0d", bus.glitch_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    int cool;
    int width;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cool = 0; width = 0;
      for (int c = 0; c < 200; c++) begin
        bus.arm = ($urandom_range(0, 9) != 0);
        bus.ack = ($urandom_range(0, 3) == 0);
        if (width > 0) begin
          bus.glitch_raw = 1'b1;
          width--;
          if (width == 0) cool = S + 3;
        end else begin
          bus.glitch_raw = 1'b0;
          if (cool > 0) cool--;
          else if ($urandom_range(0, 6) == 0) begin
            width = $urandom_range(1, 3);
            bus.glitch_raw = 1'b1;
            width--;
            if (width == 0) cool = S + 3;
          end
        end
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL random r=%0d c=%0d got=%h exp=%h", r, c, obs_vec(), exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_lockout();
    test_extend();
    test_disarmed_ack();
    test_reset_mid_wipe();
    test_saturate();
    test_short_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
